// File: rtl/approx_mac_pe.sv
// rtl/approx_mac_pe.sv - systolic MAC processing element around the approx_2 4x4 multiplier
// approx_2 builds the 4x4 product from four approximate 2x2 sub-products.

module approx_2 (
   input  logic [3:0] x_i,
   input  logic [3:0] y_i,
   output logic [7:0] p_o
);

   // The x0&y0 partial product is dropped, but 3x3 still yields 9.
   function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
      logic [3:0] full;
      full = {2'b00, x} * {2'b00, y};
      if (x == 2'd3 && y == 2'd3) begin
         mul2 = 4'd9;
      end else begin
         mul2 = full - {3'b000, x[0] & y[0]};
      end
   endfunction

   logic [3:0] ll, lh, hl, hh;

   always_comb begin
      ll  = mul2(x_i[1:0], y_i[1:0]);
      lh  = mul2(x_i[1:0], y_i[3:2]);
      hl  = mul2(x_i[3:2], y_i[1:0]);
      hh  = mul2(x_i[3:2], y_i[3:2]);
      p_o = {4'b0000, ll} + ({4'b0000, lh} << 2) + ({4'b0000, hl} << 2) + ({4'b0000, hh} << 4);
   end

endmodule

module approx_mac_pe #(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       len,
   input  logic [3:0]       a_in,
   input  logic [3:0]       b_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [3:0]       a_out,
   output logic [3:0]       b_out,
   output logic             fwd_valid,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t           state_q, state_d;
   logic [7:0]       rem_q, rem_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       p_q, p_d;
   logic             p_vld_q, p_vld_d;
   logic [3:0]       a_q, a_d, b_q, b_d;
   logic             fwd_q, fwd_d;
   logic [7:0]       prod;
   logic             accept;
   logic [ACC_W:0]   sum;

   approx_2 u_mul (
      .x_i (a_in),
      .y_i (b_in),
      .p_o (prod)
   );

   assign in_ready  = (state_q == ACC) && (rem_q != 8'd0);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == HOLD);
   assign busy      = (state_q != IDLE);
   assign a_out     = a_q;
   assign b_out     = b_q;
   assign fwd_valid = fwd_q;
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;
   assign sum       = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, p_q};

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      p_d     = p_q;
      p_vld_d = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      fwd_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACC;
               rem_d   = len;
               acc_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         ACC: begin
            // Products land in acc one cycle after capture, so HOLD waits for p_vld to drain.
            if (p_vld_q) begin
               acc_d = sum[ACC_W-1:0];
               if (sum[ACC_W]) ovf_d = 1'b1;
            end
            if (accept) begin
               rem_d   = rem_q - 8'd1;
               p_d     = prod;
               p_vld_d = 1'b1;
               a_d     = a_in;
               b_d     = b_in;
               fwd_d   = 1'b1;
            end
            if (rem_q == 8'd0 && !p_vld_q) state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         p_q     <= '0;
         p_vld_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         fwd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         p_q     <= p_d;
         p_vld_q <= p_vld_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fwd_q   <= fwd_d;
      end
   end

endmodule

// File: tb/tb_approx_mac_pe.sv
// tb/tb_approx_mac_pe.sv - directed self-checking bench for approx_mac_pe
// A 16-bit and an 8-bit accumulator instance share clock and reset.

module tb_approx_mac_pe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, in_valid, out_ready;
   logic [7:0]  len;
   logic [3:0]  a_in, b_in;
   logic        in_ready, fwd_valid, out_valid, busy, ovf;
   logic [3:0]  a_out, b_out;
   logic [15:0] acc_out;

   logic        e_start, e_in_valid, e_out_ready;
   logic [7:0]  e_len;
   logic [3:0]  e_a_in, e_b_in;
   logic        e_in_ready, e_fwd_valid, e_out_valid, e_busy, e_ovf;
   logic [3:0]  e_a_out, e_b_out;
   logic [7:0]  e_acc_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   approx_mac_pe #(.ACC_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .a_in(a_in), .b_in(b_in),
      .in_valid(in_valid), .in_ready(in_ready), .a_out(a_out), .b_out(b_out),
      .fwd_valid(fwd_valid), .acc_out(acc_out), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .ovf(ovf)
   );

   approx_mac_pe #(.ACC_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(e_start), .len(e_len), .a_in(e_a_in), .b_in(e_b_in),
      .in_valid(e_in_valid), .in_ready(e_in_ready), .a_out(e_a_out), .b_out(e_b_out),
      .fwd_valid(e_fwd_valid), .acc_out(e_acc_out), .out_valid(e_out_valid),
      .out_ready(e_out_ready), .busy(e_busy), .ovf(e_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " in_ready"},  {31'd0, in_ready},  0);
      chk({tag, " a_out"},     {28'd0, a_out},     0);
      chk({tag, " b_out"},     {28'd0, b_out},     0);
      chk({tag, " fwd_valid"}, {31'd0, fwd_valid}, 0);
      chk({tag, " acc_out"},   {16'd0, acc_out},   0);
      chk({tag, " out_valid"}, {31'd0, out_valid}, 0);
      chk({tag, " busy"},      {31'd0, busy},      0);
      chk({tag, " ovf"},       {31'd0, ovf},       0);
   endtask

   initial begin
      rst_n = 1'b0; start = 0; len = 0; a_in = 0; b_in = 0; in_valid = 0; out_ready = 0;
      e_start = 0; e_len = 0; e_a_in = 0; e_b_in = 0; e_in_valid = 0; e_out_ready = 0;
      step(); step();
      chk_reset("por");
      chk("por8 ovf", {31'd0, e_ovf}, 0);
      rst_n = 1'b1;
      step();

      // Start a job, accept one pair, then abort with an asynchronous reset.
      start = 1; len = 8'd4; step(); start = 0;
      in_valid = 1; a_in = 4'd7; b_in = 4'd9; step();
      step(); in_valid = 0;
      chk("mid busy", {31'd0, busy}, 1);
      rst_n = 1'b0; #1;
      chk_reset("midrst");
      step(); rst_n = 1'b1; step();

      // len=1, 5x5 approximates to 0.
      start = 1; len = 8'd1; step(); start = 0;
      chk("a in_ready", {31'd0, in_ready}, 1);
      in_valid = 1; a_in = 4'd5; b_in = 4'd5; step(); in_valid = 0;
      chk("a fwd", {31'd0, fwd_valid}, 1);
      chk("a a_out", {28'd0, a_out}, 5);
      chk("a in_ready drop", {31'd0, in_ready}, 0);
      step(); step();
      chk("a out_valid", {31'd0, out_valid}, 1);
      chk("a acc", {16'd0, acc_out}, 0);
      out_ready = 1; step(); out_ready = 0;
      chk("a idle", {31'd0, busy}, 0);

      // len=3 back-to-back: 225 + 6 + 9.
      start = 1; len = 8'd3; step(); start = 0;
      chk("b in_ready", {31'd0, in_ready}, 1);
      in_valid = 1; a_in = 4'd15; b_in = 4'd15; step();
      chk("b fwd0", {31'd0, fwd_valid}, 1);
      chk("b a0", {28'd0, a_out}, 15);
      a_in = 4'd2; b_in = 4'd3; step();
      chk("b fwd1", {31'd0, fwd_valid}, 1);
      chk("b a1", {28'd0, a_out}, 2);
      chk("b acc1", {16'd0, acc_out}, 225);
      a_in = 4'd3; b_in = 4'd3; step(); in_valid = 0;
      chk("b fwd2", {31'd0, fwd_valid}, 1);
      chk("b a2", {28'd0, a_out}, 3);
      chk("b b2", {28'd0, b_out}, 3);
      chk("b in_ready drop", {31'd0, in_ready}, 0);
      step();
      chk("b fwd off", {31'd0, fwd_valid}, 0);
      chk("b out_valid early", {31'd0, out_valid}, 0);
      chk("b acc t+2", {16'd0, acc_out}, 240);
      step();
      chk("b out_valid", {31'd0, out_valid}, 1);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin start = 1; len = 8'd5; end
         if (i == 4) start = 0;
         step();
         chk("b hold valid", {31'd0, out_valid}, 1);
         chk("b hold acc", {16'd0, acc_out}, 240);
      end
      out_ready = 1; step(); out_ready = 0;
      chk("b release busy", {31'd0, busy}, 0);
      chk("b release valid", {31'd0, out_valid}, 0);
      step();
      chk("b idle acc kept", {16'd0, acc_out}, 240);
      chk("b ignored start", {31'd0, busy}, 0);

      // len=2 with a 4-cycle gap: 2 + 225.
      start = 1; len = 8'd2; step(); start = 0;
      in_valid = 1; a_in = 4'd1; b_in = 4'd3; step(); in_valid = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("c gap in_ready", {31'd0, in_ready}, 1);
         chk("c gap fwd", {31'd0, fwd_valid}, 0);
         chk("c gap acc", {16'd0, acc_out}, 2);
      end
      in_valid = 1; a_in = 4'd15; b_in = 4'd15; step(); in_valid = 0;
      step(); step();
      chk("c out_valid", {31'd0, out_valid}, 1);
      chk("c acc", {16'd0, acc_out}, 227);
      out_ready = 1; step(); out_ready = 0;
      chk("c busy", {31'd0, busy}, 0);

      // Start on the cycle right after the handshake, len=0.
      start = 1; len = 8'd0; step(); start = 0;
      chk("d busy", {31'd0, busy}, 1);
      chk("d in_ready t+1", {31'd0, in_ready}, 0);
      chk("d acc cleared", {16'd0, acc_out}, 0);
      chk("d out_valid t+1", {31'd0, out_valid}, 0);
      step();
      chk("d out_valid t+2", {31'd0, out_valid}, 1);
      chk("d in_ready t+2", {31'd0, in_ready}, 0);
      chk("d acc", {16'd0, acc_out}, 0);
      out_ready = 1; step(); out_ready = 0;

      // 8-bit accumulator wraps: 450 mod 256 = 194 with ovf.
      e_start = 1; e_len = 8'd2; step(); e_start = 0;
      e_in_valid = 1; e_a_in = 4'd15; e_b_in = 4'd15; step(); step(); e_in_valid = 0;
      step(); step();
      chk("e out_valid", {31'd0, e_out_valid}, 1);
      chk("e acc", {24'd0, e_acc_out}, 194);
      chk("e ovf", {31'd0, e_ovf}, 1);
      e_out_ready = 1; step(); e_out_ready = 0;
      chk("e ovf held idle", {31'd0, e_ovf}, 1);
      e_start = 1; e_len = 8'd0; step(); e_start = 0;
      chk("e ovf cleared", {31'd0, e_ovf}, 0);
      chk("main ovf", {31'd0, ovf}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/approx_mac_pe.md
# approx_mac_pe

Systolic processing element wrapping one approx_2 4x4 approximate multiplier. It accepts a programmed number of 4-bit operand pairs over a valid/ready handshake and forwards each accepted pair, registered, to the neighbouring PE. It accumulates the approximate products and presents the dot-product result on an output valid/ready port. It sits directly downstream of approx_2, consuming its 8-bit product, and forms the MAC cell of the Strassen systolic array.

## Interface
- ACC_W, 16, accumulator and result width (must be >= 8)
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; starts a job, sampled only in IDLE
- len  in  8  operand pairs in the job, sampled with start
- a_in  in  4  multiplicand
- b_in  in  4  multiplier
- in_valid  in  1  operand pair valid
- in_ready  out  1  PE can accept a pair
- a_out  out  4  registered copy of last accepted a_in
- b_out  out  4  registered copy of last accepted b_in
- fwd_valid  out  1  one-cycle pulse; a_out/b_out carry a new pair
- acc_out  out  ACC_W  accumulated result
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- busy  out  1  state != IDLE
- ovf  out  1  sticky; accumulator carry-out occurred during the current job

## Operation
- Product is computed by an internal approx_2 instance; the PE must not correct it.
  - Each 2x2 sub-product drops the x0&y0 term.
  - Each 2x2 sub-product maps 3x3 to 9.
- States:
  - IDLE -> ACC on start.
    - Load rem = len.
    - Clear acc and ovf.
    - If len == 0, go ACC -> HOLD with no input accepted.
  - ACC: accept pairs while rem > 0.
    - On accept: rem decrements, and the product is captured in p_reg with p_vld.
    - On the following edge: acc += zero-extended p_reg.
    - Carry out of ACC_W bits wraps acc and sets ovf.
  - ACC -> HOLD once rem == 0 and no product is pending in p_reg.
  - HOLD -> IDLE on out_valid && out_ready.
- in_ready = (state == ACC) && rem != 0. Accept = in_valid && in_ready.
- Forwarding: a_out/b_out update only on accept. fwd_valid = 1 the cycle after each accept, else 0.
- start outside IDLE is ignored. len is ignored except with an accepted start.
- acc_out holds its value after HOLD -> IDLE until the next start clears it.
- ovf holds its value after HOLD -> IDLE until the next start clears it.

## Timing
- Reset values: state IDLE; in_ready 0; a_out 0; b_out 0; fwd_valid 0; acc_out 0; out_valid 0; busy 0; ovf 0; p_vld 0; rem 0.
- Reset asserted mid-job aborts immediately. Nothing is retained.
- start at cycle t: in_ready = 1 from cycle t+1 (len > 0).
- start at cycle t with len = 0: out_valid = 1 at cycle t+2 with acc_out = 0.
- Accept at cycle t:
  - a_out/b_out/fwd_valid reflect the pair at t+1.
  - p_reg holds the product at t+1.
  - The product is included in acc_out at t+2.
- Last accept at cycle t: in_ready drops at t+1, and out_valid rises at t+3.
- in_valid may stall arbitrarily. The PE accumulates nothing while no pair is accepted.
- out_valid stays high, and acc_out stays stable, until out_ready is sampled high.
- Handshake cycle: busy = 0 on the next cycle. A start on that next cycle is accepted.
- Back-to-back accepts sustain one pair per clock.

## Test plan
- Reset mid-job, then start len=1, a=5, b=5:
  - Reset: all outputs return to their reset values.
  - Result: acc_out = 0, because approx 5x5 = 0.
- start len=3, pairs (15,15), (2,3), (3,3) streamed back-to-back:
  - acc_out = 225+6+9 = 240, out_valid at cycle 5 after start+1.
  - fwd_valid high 3 cycles, a_out sequence 15, 2, 3.
- start len=2, in_valid gapped 4 cycles between pairs (1,3), (15,15):
  - acc_out = 2+225 = 227.
  - in_ready holds during the gap.
- start len=0:
  - out_valid two cycles later, acc_out = 0.
  - in_ready never asserted.
- ACC_W=8, len=2, (15,15)x2:
  - acc_out = 450 mod 256 = 194, ovf = 1.
  - A new start clears ovf.
- Completed job with out_ready held low 10 cycles:
  - out_valid and acc_out stable throughout.
  - start pulsed while in HOLD is ignored.
  - The IDLE return follows out_ready.
